// File: rtl/mux3_select_sequencer.sv
// rtl/mux3_select_sequencer.sv - u/v/w mux select sequencer: timed auto-scan or push-button single-step.
// Optional SEQ_MASK_EN adds en_mask[2:0] to skip disabled channels.
module mux3_select_sequencer #(
    parameter int DWELL = 100_000_000,
    parameter int CNT_W = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
`ifdef SEQ_MASK_EN
    input  logic [2:0] en_mask,
`endif
    output logic       s0,
    output logic       s1,
    output logic [1:0] chan,
    output logic       tick
);

    typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             step_e;
    logic             adv;
    logic [2:0]       mask;
    logic [1:0]       c1;
    logic [1:0]       c2;
    logic [1:0]       nxt;

`ifdef SEQ_MASK_EN
    assign mask = en_mask;
`else
    assign mask = 3'b111;
`endif

    function automatic logic [1:0] inc3(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign step_e = step & ~step_q;

    // A step on the PAUSE->RUN edge is dropped; in RUN a falling run beats the terminal count.
    always_comb begin
        adv = 1'b0;
        if (state == PAUSE)
            adv = step_e & ~run;
        else
            adv = run & (cnt == CNT_LAST);
    end

    // Next enabled channel in 0->1->2->0 order; falls back to the current one.
    always_comb begin
        c1  = inc3(chan);
        c2  = inc3(c1);
        nxt = chan;
        if (mask[c1])
            nxt = c1;
        else if (mask[c2])
            nxt = c2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= PAUSE;
            cnt    <= '0;
            step_q <= 1'b1;
            chan   <= 2'd0;
            s0     <= 1'b0;
            s1     <= 1'b0;
            tick   <= 1'b0;
        end else begin
            step_q <= step;

            case (state)
                PAUSE: begin
                    cnt <= '0;
                    if (run)
                        state <= RUN;
                end
                RUN: begin
                    if (!run) begin
                        state <= PAUSE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= PAUSE;
                    cnt   <= '0;
                end
            endcase

            // An empty mask parks the mux on u while the dwell timing keeps running.
            if (mask == 3'b000) begin
                chan <= 2'd0;
                s0   <= 1'b0;
                s1   <= 1'b0;
                tick <= 1'b0;
            end else if (adv) begin
                chan <= nxt;
                s0   <= (nxt == 2'd1);
                s1   <= (nxt == 2'd2);
                tick <= 1'b1;
            end else begin
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux3_select_sequencer.sv
// tb/tb_mux3_select_sequencer.sv - directed vector bench for mux3_select_sequencer (DWELL=4).
module tb_mux3_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       s0;
    logic       s1;
    logic [1:0] chan;
    logic       tick;
`ifdef SEQ_MASK_EN
    logic [2:0] en_mask;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mux3_select_sequencer #(.DWELL(4), .CNT_W(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .step   (step),
`ifdef SEQ_MASK_EN
        .en_mask(en_mask),
`endif
        .s0     (s0),
        .s1     (s1),
        .chan   (chan),
        .tick   (tick)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic       run;
        logic       step;
        logic [1:0] chan;
        logic [1:0] sel;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic ru, input logic st,
                       input logic [1:0] c, input logic t);
        vec_t v;
        v.name = n; v.rst_n = r; v.run = ru; v.step = st; v.chan = c; v.tick = t;
        v.sel = (c == 2'd1) ? 2'b01 : (c == 2'd2) ? 2'b10 : 2'b00;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [1:0] ec, input logic et);
        logic [1:0] es;
        es = (ec == 2'd1) ? 2'b01 : (ec == 2'd2) ? 2'b10 : 2'b00;
        total++;
        if (chan === ec && {s1, s0} === es && tick === et)
            passed++;
        else
            $display("FAIL %s: got chan=%0d s1s0=%b tick=%b, expected chan=%0d s1s0=%b tick=%b",
                     n, chan, {s1, s0}, tick, ec, es, et);
    endtask

    task automatic cycle(input logic r, input logic ru, input logic st);
        rst_n = r; run = ru; step = st;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b1;
`ifdef SEQ_MASK_EN
        en_mask = 3'b111;
`endif
        // reset with step held high, then release: no phantom step
        add("rst_a",   0, 0, 1, 0, 0);
        add("rst_b",   0, 0, 1, 0, 0);
        add("rel_a",   1, 0, 1, 0, 0);
        add("rel_b",   1, 0, 1, 0, 0);
        add("rel_lo",  1, 0, 0, 0, 0);
        // three step pulses in PAUSE
        add("step1",   1, 0, 1, 1, 1);
        add("hold1",   1, 0, 1, 1, 0);
        add("low1",    1, 0, 0, 1, 0);
        add("step2",   1, 0, 1, 2, 1);
        add("low2",    1, 0, 0, 2, 0);
        add("step3",   1, 0, 1, 0, 1);
        add("low3",    1, 0, 0, 0, 0);
        // run for 13 edges; step edge on PAUSE->RUN edge is ignored
        add("go",      1, 1, 1, 0, 0);
        add("r1",      1, 1, 0, 0, 0);
        add("r2",      1, 1, 0, 0, 0);
        add("r3",      1, 1, 0, 0, 0);
        add("adv_v",   1, 1, 0, 1, 1);
        add("r5",      1, 1, 0, 1, 0);
        add("r6",      1, 1, 0, 1, 0);
        add("r7",      1, 1, 0, 1, 0);
        add("adv_w",   1, 1, 0, 2, 1);
        add("r9",      1, 1, 0, 2, 0);
        add("r10",     1, 1, 0, 2, 0);
        add("r11",     1, 1, 0, 2, 0);
        add("adv_u",   1, 1, 0, 0, 1);
        // step pulses in RUN, then drop run at terminal count
        add("rstep_a", 1, 1, 1, 0, 0);
        add("rstep_b", 1, 1, 0, 0, 0);
        add("rstep_c", 1, 1, 1, 0, 0);
        add("drop",    1, 0, 0, 0, 0);
        add("rego",    1, 1, 0, 0, 0);
        add("q1",      1, 1, 1, 0, 0);
        add("q2",      1, 1, 0, 0, 0);
        add("q3",      1, 1, 0, 0, 0);
        add("readv",   1, 1, 0, 1, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst_n, vecs[i].run, vecs[i].step);
            check(vecs[i].name, vecs[i].chan, vecs[i].tick);
        end

        // advance to w in RUN, then reset mid-dwell
        for (int i = 0; i < 3; i++) cycle(1, 1, 0);
        cycle(1, 1, 0);
        check("to_w", 2, 1);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        check("mid_rst", 0, 0);
        // post-reset: must pass through PAUSE, so advance takes 5 edges
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 1, 0);
            check($sformatf("post_rst_%0d", i), 0, 0);
        end
        cycle(1, 1, 0);
        check("post_rst_adv", 1, 1);

`ifdef SEQ_MASK_EN
        cycle(0, 0, 0);
        en_mask = 3'b101;
        cycle(1, 1, 0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) cycle(1, 1, 0);
            cycle(1, 1, 0);
            check($sformatf("mask101_%0d", k), (k % 2 == 0) ? 2'd2 : 2'd0, 1);
        end
        en_mask = 3'b000;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0);
            check($sformatf("mask000_%0d", i), 0, 0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
